// File: rtl/display_mux_scheduler.sv
// Two-digit seven-segment multiplexer: alternates two hex digits onto one shared
// decoder bus with a programmable dwell per digit and dead time between digits.
module display_mux_scheduler #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_WIDTH    = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] s,
  output logic       anode1,
  output logic       anode2,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW1  = 3'd1,
    BLANK1 = 3'd2,
    SHOW2  = 3'd3,
    BLANK2 = 3'd4
  } state_t;

  // With no dead time the BLANK states are unreachable and their terminal count is unused.
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           s_q, s_d;
  logic                 frame_tick_q, frame_tick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s_q          <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // The digit value is captured only on entry to a SHOW state, so a switch change
  // mid-dwell never disturbs the digit currently lit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_d          = s_q;
    frame_tick_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = SHOW1;
          cnt_d        = '0;
          s_d          = s1;
          frame_tick_d = 1'b1;
        end
        SHOW1: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) begin
              state_d = BLANK1;
            end else begin
              state_d = SHOW2;
              s_d     = s2;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BLANK1: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW2;
            s_d     = s2;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        SHOW2: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) begin
              state_d = BLANK2;
            end else begin
              state_d      = SHOW1;
              s_d          = s1;
              frame_tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BLANK2: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d        = '0;
            state_d      = SHOW1;
            s_d          = s1;
            frame_tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Anodes decode straight from the state register, so only one can ever be low.
  assign anode1     = (state_q != SHOW1);
  assign anode2     = (state_q != SHOW2);
  assign s          = s_q;
  assign frame_tick = frame_tick_q;

endmodule
